// File: rtl/seg_pkg.sv
// Shared segment definitions: active-low pattern table used by both the
// hex-to-segment encoder and the segment-to-hex decoder.
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam int NUM_DIGITS = 4;

  // Index is the nibble value; bit0=a ... bit6=g, active-low.
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a nibble.
// Unknown patterns decode to 0 with o_err set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t    i_seg,
  output nibble_t o_nibble,
  output logic    o_err
);

  always_comb begin
    o_nibble = '0;
    o_err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_LUT[i]) begin
        o_nibble = 4'(i);
        o_err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 4-digit active-low 7-segment bus and recovers the
// displayed 16-bit value. Optional decimal points: SEG_SCAN_DECODER_DP_EN.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CNT  = 4,
  parameter int SYNC_STAGES = 2
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
`ifdef SEG_SCAN_DECODER_DP_EN
  input  logic        dp_n,
  output logic [3:0]  out_dp,
`endif
  output logic [15:0] out_value,
  output logic        out_error,
  output logic        out_valid,
  input  logic        out_ready
);

  // Handshake: a frame moves when out_valid && out_ready on a rising edge;
  // out_value/out_error (and out_dp) stay stable while out_valid is high.

`ifdef SEG_SCAN_DECODER_DP_EN
  localparam int SW = 12;
  logic [SW-1:0] w_in;
  assign w_in = {an_n, dp_n, seg_n};
`else
  localparam int SW = 11;
  logic [SW-1:0] w_in;
  assign w_in = {an_n, seg_n};
`endif

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

  logic [SW-1:0] r_sync [SYNC_STAGES];
  logic [SW-1:0] r_prev;
  logic [7:0]    r_cnt;
  logic [3:0]    r_captured;
  nibble_t       r_dig  [NUM_DIGITS];
  logic [3:0]    r_derr;
  logic [3:0]    r_ddp;
  logic [3:0]    r_dp_out;

  logic [SW-1:0] w_sample;
  logic [3:0]    w_an_act;
  seg_t          w_seg;
  logic          w_dp_lit;
  logic          w_valid;
  logic          w_same;
  logic [7:0]    w_cnt_next;
  logic          w_cap;
  logic [3:0]    w_cap_mask;
  logic [1:0]    w_idx;
  nibble_t       w_nib;
  logic          w_err;
  logic          w_load;

  assign w_sample = r_sync[SYNC_STAGES-1];
  assign w_an_act = ~w_sample[SW-1 -: 4];
  assign w_seg    = w_sample[6:0];
`ifdef SEG_SCAN_DECODER_DP_EN
  assign w_dp_lit = ~w_sample[7];
  assign out_dp   = r_dp_out;
`else
  assign w_dp_lit = 1'b0;
`endif

  // Exactly one anode active: non-zero and a power of two.
  assign w_valid = (w_an_act != 4'd0) && ((w_an_act & (w_an_act - 4'd1)) == 4'd0);
  assign w_same  = (w_sample == r_prev);

  always_comb begin
    w_cnt_next = 8'd0;
    if (w_valid) begin
      if (w_same && (r_cnt != 8'd0))
        w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 8'd1;
      else
        w_cnt_next = 8'd1;
    end
  end

  // A saturated counter on an unchanged sample means this digit was already taken.
  assign w_cap      = w_valid && (w_cnt_next == CNT_MAX) && !(w_same && (r_cnt == CNT_MAX));
  assign w_cap_mask = w_cap ? w_an_act : 4'd0;

  always_comb begin
    w_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_act[i]) w_idx = 2'(i);
    end
  end

  seg_pattern_decode u_decode (
    .i_seg    (w_seg),
    .o_nibble (w_nib),
    .o_err    (w_err)
  );

  assign w_load = (r_captured == 4'hF) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '1;
      r_prev <= '1;
      r_cnt  <= 8'd0;
    end else begin
      r_sync[0] <= w_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_sample;
      r_cnt  <= w_cnt_next;
    end
  end

  // Load uses the digit registers before this cycle's capture; the capture
  // then marks its digit as the first of the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= '0;
      r_derr     <= 4'd0;
      r_ddp      <= 4'd0;
      r_captured <= 4'd0;
      out_value  <= 16'd0;
      out_error  <= 1'b0;
      out_valid  <= 1'b0;
      r_dp_out   <= 4'd0;
    end else begin
      if (w_cap) begin
        r_dig[w_idx]  <= w_nib;
        r_derr[w_idx] <= w_err;
        r_ddp[w_idx]  <= w_dp_lit;
      end
      if (w_load) begin
        out_value  <= {r_dig[3], r_dig[2], r_dig[1], r_dig[0]};
        out_error  <= |r_derr;
        r_dp_out   <= r_ddp;
        out_valid  <= 1'b1;
        r_captured <= w_cap_mask;
      end else begin
        r_captured <= r_captured | w_cap_mask;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reverse of the hex-to-seven-segment path. Observes a multiplexed 4-digit, active-low 7-segment bus (segment pattern plus digit anodes) and recovers the 16-bit hex value being displayed.
- Used as a display monitor and loopback checker behind the segment drivers.
- Each digit pattern is debounced, decoded back to a nibble and assembled into a frame, which is delivered over a valid/ready handshake.

Parameters:
- STABLE_CNT, 4: consecutive identical synchronized samples required before a digit is captured. Legal range 1..255.
- SYNC_STAGES, 2: flop stages on seg_n/an_n (and dp_n) before use. Legal range 2..4.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_n  input  7  active-low segment pattern; bit0=a … bit6=g.
- an_n  input  4  active-low digit enables; bit i selects digit i (digit 3 = most significant nibble).
- out_value  output  16  decoded frame, digit i in bits [4i+3:4i].
- out_error  output  1  at least one digit in the frame had an unrecognised pattern.
- out_valid  output  1  frame available.
- out_ready  input  1  consumer accepts the frame.

Behaviour:
- Reset: out_value=0, out_error=0, out_valid=0. Synchronizers cleared to 1 (idle, active-low). Stability counter=0, captured mask=0, digit registers=0.
- Sample validity: after synchronization, a sample is valid only when exactly one an_n bit is low. If all bits are high or more than one is low, the counter resets to 0 and nothing is captured.
- Debounce: the counter increments while the valid sample {an_n, seg_n} equals the previous cycle's sample. Any change reloads the counter to 1.
- Capture: when the counter reaches STABLE_CNT, capture the decoded nibble and error bit into digit register i and set captured[i]. The counter saturates, so a held digit is captured once.
- Latency: input change to capture = SYNC_STAGES + STABLE_CNT cycles.
- Decode table (seg_n hex to nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - Any other pattern decodes to nibble 0 with digit error=1.
- Frame complete: captured==4'hF. Re-capturing a digit before completion overwrites it, so the latest value wins.
- Output load: when the frame is complete and (out_valid==0 or out_ready==1), load the output registers; out_valid is registered high the next cycle.
  - out_value = concatenated digit registers.
  - out_error = OR of the four digit error bits.
  - captured is cleared in the same cycle.
- Simultaneous capture and output load: a capture landing in the load cycle sets its captured bit after the clear, and is included in the loaded frame's data only if it precedes the load.
- Handshake: out_valid stays high and out_value/out_error are held stable until out_valid && out_ready. A transfer with no new complete frame drops out_valid the next cycle.
- Back-pressure: a complete frame waits (captured stays F, digits keep refreshing) and loads the cycle after the transfer. There is no frame drop counter.
- rst mid-operation returns everything to reset values on the next edge; a partially built frame is discarded.

Optional Feature:
- Macro SEG_SCAN_DECODER_DP_EN.
- Defined:
  - Adds input dp_n (1 bit, active-low decimal point), synchronized and debounced together with seg_n.
  - Adds output out_dp (4 bits, 1=point lit on digit i), loaded and held with out_value. Reset value 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Shared package seg_pkg holds:
  - typedef seg_t (logic [6:0]) and nibble_t (logic [3:0]);
  - localparam array SEG_LUT[16] of active-low patterns;
  - NUM_DIGITS=4.
- The same table also drives the encoder side, so the two cannot diverge.
- One sub-module, seg_pattern_decode: purely combinational seg_t → {nibble_t, err}, a table search over SEG_LUT.

Test Plan:
- Static scan: digits 3..0 show patterns 12,24,30,19, each held 8 cycles, out_ready=1 → out_value=16'h5234, out_error=0, single out_valid pulse per full scan.
- Glitch rejection (STABLE_CNT=4): digit 0 shows 79 for 3 cycles, then 24 for 6 → digit 0 captured as 2, never 1.
- Invalid pattern: digit 2 shows 7F (blank) while others are valid → out_error=1 and nibble 2 reads 0.
- Back-pressure: out_ready=0 across two full scans (1111 then 2222) → out_value holds 16'h1111. On out_ready=1, transfers 1111, then 2222 appears next cycle.
- Bus faults: an_n=4'b1111 and an_n=4'b0011 held 20 cycles → no capture, captured unchanged. rst asserted after 2 digits → no frame emitted, outputs 0.
- (DP_EN) dp_n low on digit 1 only → out_dp=4'b0010 with the frame.
